// File: rtl/anu_fifo_sync_param_if.sv
// Handshake bundle for anu_fifo_sync_param: write side, read side, status flags and error flags.
// The slave modport is the FIFO core; the master modport is whatever feeds and drains it.
interface anu_fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  modport slave (
    input  flush, wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport master (
    output flush, wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/anu_fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and flush.
// Define FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags (tied to 0 otherwise).
module anu_fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  anu_fifo_sync_param_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Status is always a pure decode of the count register, never of pointer equality.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wr_ok = bus.wr_en & ~w_full  & ~bus.flush;
  assign w_rd_ok = bus.rd_en & ~w_empty & ~bus.flush;

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_wr_ok) begin
      r_mem[r_wptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (bus.flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_wr_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Clear first so a coincident violation in the same cycle overrides err_clr.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      if (bus.wr_en && w_full && !bus.flush) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd_en && w_empty && !bus.flush) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;
  assign bus.overflow     = 1'b0;
  assign bus.underflow    = 1'b0;
`endif

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
  assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
  assign bus.count        = r_count;
endmodule

// File: tb/tb_anu_fifo_sync_param.sv
// Self-checking bench for anu_fifo_sync_param: a queue-based reference model compared every cycle,
// plus directed sequences with literal expectations (fill/drain, wrap, full, empty, flush, reset).
module tb_anu_fifo_sync_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = DEPTH - 2;
  localparam int AE     = 2;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  anu_fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  anu_fifo_sync_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the registered read-side state.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_rd_data;
  bit                m_rd_valid;
  bit                m_ovf;
  bit                m_udf;

  always @(posedge clk) begin
    bit m_full, m_empty, wok, rok;
    if (!rst_n) begin
      m_q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
    end else begin
      m_full  = (m_q.size() == DEPTH);
      m_empty = (m_q.size() == 0);
      wok = bus.wr_en && !m_full  && !bus.flush;
      rok = bus.rd_en && !m_empty && !bus.flush;
      if (ERR_EN) begin
        if (bus.err_clr) begin
          m_ovf = 1'b0;
          m_udf = 1'b0;
        end
        if (bus.wr_en && m_full  && !bus.flush) m_ovf = 1'b1;
        if (bus.rd_en && m_empty && !bus.flush) m_udf = 1'b1;
      end
      m_rd_valid = rok;
      if (bus.flush) begin
        m_q.delete();
      end else begin
        if (rok) m_rd_data = m_q.pop_front();
        if (wok) m_q.push_back(bus.wr_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",        bus.count,        m_q.size());
      chk("empty",        bus.empty,        m_q.size() == 0);
      chk("full",         bus.full,         m_q.size() == DEPTH);
      chk("almost_full",  bus.almost_full,  m_q.size() >= AF);
      chk("almost_empty", bus.almost_empty, m_q.size() <= AE);
      chk("rd_valid",     bus.rd_valid,     m_rd_valid);
      chk("rd_data",      bus.rd_data,      m_rd_data);
      chk("overflow",     bus.overflow,     m_ovf);
      chk("underflow",    bus.underflow,    m_udf);
    end
  end

  task automatic step(input bit wr, input logic [DATA_W-1:0] wd, input bit rd,
                      input bit fl, input bit ec);
    bus.wr_en   = wr;
    bus.wr_data = wd;
    bus.rd_en   = rd;
    bus.flush   = fl;
    bus.err_clr = ec;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    step(0, 8'h00, 0, 0, 0);
    chk_en = 1'b1;
    step(0, 8'h00, 0, 0, 0);
    chk("rst count", bus.count, 0);
    chk("rst empty", bus.empty, 1);
    chk("rst almost_empty", bus.almost_empty, 1);
    chk("rst rd_valid", bus.rd_valid, 0);
    chk("rst rd_data", bus.rd_data, 8'h00);
    rst_n = 1'b1;

    // Fill and drain
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 12) chk("fill af@13", bus.almost_full, 0);
      if (i == 13) chk("fill af@14", bus.almost_full, 1);
      if (i == 14) chk("fill full@15", bus.full, 0);
    end
    chk("fill full", bus.full, 1);
    chk("fill count", bus.count, 16);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 8'h00, 1, 0, 0);
      chk("drain rd_valid", bus.rd_valid, 1);
      chk("drain rd_data", bus.rd_data, i);
    end
    step(0, 8'h00, 0, 0, 0);
    chk("drain idle rd_valid", bus.rd_valid, 0);
    chk("drain empty", bus.empty, 1);

    // Wrap: advance pointers to 10, then interleave across the wrap
    for (int i = 0; i < 10; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0, 0);
    chk("wrap pre rd_data", bus.rd_data, 8'h29);
    for (int i = 0; i < 6; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    for (int i = 6; i < 12; i++) step(1, 8'(8'h40 + i), 1, 0, 0);
    chk("wrap mid count", bus.count, 6);
    chk("wrap mid rd_data", bus.rd_data, 8'h45);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0);
    chk("wrap end rd_data", bus.rd_data, 8'h4B);
    chk("wrap end empty", bus.empty, 1);

    // Full with simultaneous write and read
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
    step(1, 8'hEE, 1, 0, 0);
    chk("full wr+rd count", bus.count, 15);
    chk("full wr+rd rd_data", bus.rd_data, 8'h80);
    chk("full overflow", bus.overflow, ERR_EN ? 1 : 0);
    for (int i = 1; i < DEPTH; i++) step(0, 8'h00, 1, 0, 0);
    chk("full drain last", bus.rd_data, 8'h8F);
    step(0, 8'h00, 0, 0, 1);
    chk("ovf cleared", bus.overflow, 0);

    // Empty read and error clearing
    step(0, 8'h00, 1, 0, 0);
    chk("empty rd_valid", bus.rd_valid, 0);
    chk("underflow set", bus.underflow, ERR_EN ? 1 : 0);
    step(0, 8'h00, 0, 0, 1);
    chk("underflow clr", bus.underflow, 0);
    step(0, 8'h00, 1, 0, 1);
    chk("set beats clr", bus.underflow, ERR_EN ? 1 : 0);
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h5A, 1, 0, 0);
    chk("empty wr+rd rd_valid", bus.rd_valid, 0);
    chk("empty wr+rd count", bus.count, 1);
    step(0, 8'h00, 1, 0, 0);
    chk("empty wr+rd pop", bus.rd_data, 8'h5A);

    // Flush
    for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    chk("pre-flush count", bus.count, 5);
    step(1, 8'h33, 1, 1, 0);
    chk("flush count", bus.count, 0);
    chk("flush empty", bus.empty, 1);
    chk("flush rd_valid", bus.rd_valid, 0);
    chk("flush rd_data held", bus.rd_data, 8'h5A);
    step(1, 8'hA5, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("post-flush rd_data", bus.rd_data, 8'hA5);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    rst_n = 1'b0;
    step(1, 8'h77, 1, 0, 0);
    chk("midrst count", bus.count, 0);
    chk("midrst rd_data", bus.rd_data, 8'h00);
    rst_n = 1'b1;
    step(1, 8'hC3, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("midrst first pop", bus.rd_data, 8'hC3);
    step(0, 8'h00, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
